my_gpio_input: RTL
==================

MY_GPIO_INPUT -- requirements
Module: my_gpio_input

Interface
REQ-001 Parameter DATA_WIDTH SHALL be: DATA_WIDTH, default 8, number of GPIO input pins and width of data_out.
REQ-002 Parameter DEBOUNCE_CYCLES SHALL be: DEBOUNCE_CYCLES, default 4, number of consecutive stable cycles required to accept a new pin value (legal range 1..255).
REQ-003 Port clk SHALL be: clk, input, 1, single system clock; all state changes on its rising edge.
REQ-004 Port rst SHALL be: rst, input, 1, asynchronous active-low reset.
REQ-005 Port pins_in SHALL be: pins_in, input, DATA_WIDTH, raw asynchronous switch inputs.
REQ-006 Port ctrl_ack SHALL be: ctrl_ack, input, 1, CPU acknowledge strobe; clears pending change state.
REQ-007 Port data_out SHALL be: data_out, output, DATA_WIDTH, registered debounced pin value read by the CPU.
REQ-008 Port change_mask SHALL be: change_mask, output, DATA_WIDTH, sticky mask of bits changed since last ack.
REQ-009 Port irq_out SHALL be: irq_out, output, 1, level trap request; high while change_mask is non-zero.

Function
REQ-010 pins_in SHALL pass through a two-flop synchronizer; only the second-stage value (sync) is used downstream.
REQ-011 Debounce FSM SHALL have states IDLE and COUNT, with an 8-bit counter cnt.
REQ-012 In IDLE with sync == data_out: stay IDLE, cnt = 0.
REQ-013 In IDLE with sync != data_out: go to COUNT, capture sync into candidate, cnt = 1.
REQ-014 In COUNT with sync != candidate: restart by capturing the new sync into candidate, cnt = 1, or go to IDLE with cnt = 0 if sync == data_out.
REQ-015 In COUNT with sync == candidate and cnt < DEBOUNCE_CYCLES: cnt increments.
REQ-016 In COUNT with sync == candidate and cnt == DEBOUNCE_CYCLES: data_out <= candidate and go to IDLE with cnt = 0 in the same edge.
REQ-017 A pin change held stable SHALL appear on data_out exactly 2 + DEBOUNCE_CYCLES rising edges after the first edge that samples it.
REQ-018 On a data_out update, change_mask SHALL OR in (candidate XOR old data_out).
REQ-019 When ctrl_ack is high for one cycle, change_mask SHALL clear to 0 at that edge.
REQ-020 If ctrl_ack coincides with a data_out update, change_mask SHALL become exactly the new changed bits; the update is not lost.
REQ-021 irq_out SHALL equal (change_mask != 0), registered, so it has no extra cycle delay relative to change_mask.
REQ-022 ctrl_ack while change_mask == 0 SHALL have no effect.
REQ-023 A bounce shorter than DEBOUNCE_CYCLES stable cycles SHALL never alter data_out or change_mask.

Reset
REQ-024 While rst is low: synchronizer flops, candidate, data_out and change_mask SHALL be 0, irq_out SHALL be 0, FSM SHALL be IDLE and cnt SHALL be 0, all asynchronously.
REQ-025 Reset asserted mid-COUNT SHALL discard the candidate; after release, debounce SHALL restart from IDLE.

Configuration
REQ-026 Macro MY_GPIO_INPUT_IRQ_EN defined SHALL build change_mask and irq_out as specified.
REQ-027 With MY_GPIO_INPUT_IRQ_EN undefined, change_mask and irq_out SHALL be constant 0, ctrl_ack SHALL be ignored, and no mask flops are generated; debounce is unchanged.

Structure
REQ-028 Package my_gpio_pkg SHALL hold the FSM state typedef (IDLE, COUNT), the default DATA_WIDTH, the default DEBOUNCE_CYCLES, and the counter width constant (8).
REQ-029 The two-flop synchronizer SHALL be sub-module my_synchronizer, parameterized by DATA_WIDTH, using the same clk and rst.

Verification (DATA_WIDTH=8, DEBOUNCE_CYCLES=4)
REQ-030 Reset check: hold rst low, pins_in=8'hFF -> data_out=0, change_mask=0, irq_out=0; after release, data_out=8'hFF exactly 6 edges later, change_mask=8'hFF, irq_out=1.
REQ-031 Bounce rejection: from data_out=0, drive pins_in=8'h01 for 3 cycles then 8'h00 -> data_out stays 0 and irq_out stays 0.
REQ-032 Ack: from change_mask=8'h01, pulse ctrl_ack -> change_mask=0 and irq_out=0 next edge, with data_out=8'h01 unchanged.
REQ-033 Simultaneous ack and update: drive pins 8'h01->8'h03 stable while ctrl_ack pulses on the update edge -> change_mask=8'h02 and irq_out=1.
REQ-034 Reset mid-COUNT: drive pins_in=8'h80, assert rst after 3 edges, release -> data_out=0 until 6 further stable edges, then 8'h80.
REQ-035 Build without MY_GPIO_INPUT_IRQ_EN, toggle pins_in=8'h55 stable -> data_out=8'h55 after 6 edges, while irq_out and change_mask stay 0 throughout.

Source files
------------

// File: rtl/my_gpio_pkg.sv
// Shared types and defaults for the debounced GPIO input block.
// Counter width and FSM state encoding live here.
package my_gpio_pkg;

  localparam int GPIO_DATA_WIDTH      = 8;
  localparam int GPIO_DEBOUNCE_CYCLES = 4;
  localparam int CNT_W                = 8;

  typedef enum logic {
    IDLE,
    COUNT
  } dbnc_state_e;

endpackage

// File: rtl/my_gpio_input_if.sv
// Pin/CPU-facing bundle of the GPIO input block.
// master = CPU/pad side, slave = the GPIO block.
interface my_gpio_input_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] pins_in;
  logic                  ctrl_ack;
  logic [DATA_WIDTH-1:0] data_out;
  logic [DATA_WIDTH-1:0] change_mask;
  logic                  irq_out;

  modport master (
    output pins_in,
    output ctrl_ack,
    input  data_out,
    input  change_mask,
    input  irq_out
  );

  modport slave (
    input  pins_in,
    input  ctrl_ack,
    output data_out,
    output change_mask,
    output irq_out
  );

endinterface

// File: rtl/my_synchronizer.sv
// Two-flop synchronizer for the raw switch inputs.
// Only the second stage is used downstream.
module my_synchronizer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] q_o
);

  logic [DATA_WIDTH-1:0] meta_q;
  logic [DATA_WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/my_gpio_input.sv
// Debounced GPIO input with sticky change mask and level irq.
// Define MY_GPIO_INPUT_IRQ_EN to build change_mask/irq_out.
module my_gpio_input
  import my_gpio_pkg::*;
#(
  parameter int DATA_WIDTH      = GPIO_DATA_WIDTH,
  parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  my_gpio_input_if.slave   bus
);

  localparam logic [CNT_W-1:0] LAST_CNT =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [DATA_WIDTH-1:0] sync;
  logic [DATA_WIDTH-1:0] cand_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CNT_W-1:0]      cnt_q;
  dbnc_state_e           state_q;
  logic                  upd_d;
  logic [DATA_WIDTH-1:0] new_d;

  my_synchronizer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.pins_in),
    .q_o (sync)
  );

  // The COUNT entry edge is the first stable sample, so the
  // commit fires on the edge that would bring cnt to DEBOUNCE.
  always_comb begin
    upd_d = 1'b0;
    new_d = data_q;
    unique case (state_q)
      IDLE: begin
        if (sync != data_q && LAST_CNT == '0) begin
          upd_d = 1'b1;
          new_d = sync;
        end
      end
      COUNT: begin
        if (sync == cand_q && cnt_q >= LAST_CNT) begin
          upd_d = 1'b1;
          new_d = cand_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      data_q  <= '0;
    end else begin
      if (upd_d) data_q <= new_d;
      unique case (state_q)
        IDLE: begin
          if (!upd_d && sync != data_q) begin
            state_q <= COUNT;
            cand_q  <= sync;
            cnt_q   <= CNT_W'(1);
          end else begin
            cnt_q <= '0;
          end
        end
        COUNT: begin
          if (upd_d) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (sync != cand_q) begin
            if (sync == data_q) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else begin
              cand_q <= sync;
              cnt_q  <= CNT_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign bus.data_out = data_q;

`ifdef MY_GPIO_INPUT_IRQ_EN
  logic [DATA_WIDTH-1:0] mask_q;
  logic [DATA_WIDTH-1:0] mask_d;
  logic                  irq_q;

  // An ack on an update edge keeps only the freshly changed bits.
  always_comb begin
    mask_d = bus.ctrl_ack ? '0 : mask_q;
    if (upd_d) mask_d = mask_d | (new_d ^ data_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= |mask_d;
    end
  end

  assign bus.change_mask = mask_q;
  assign bus.irq_out     = irq_q;
`else
  logic unused_ack;
  assign unused_ack      = bus.ctrl_ack;
  assign bus.change_mask = '0;
  assign bus.irq_out     = 1'b0;
`endif

endmodule
